// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed seven-segment scan controller:
// register map, CTRL field positions, register-set layout and the hex glyph table.
package seg_pkg;

  localparam logic [11:0] OFF_DATA   = 12'h000;
  localparam logic [11:0] OFF_CTRL   = 12'h004;
  localparam logic [11:0] OFF_DP     = 12'h008;
  localparam logic [11:0] OFF_RAW_LO = 12'h00C;
  localparam logic [11:0] OFF_RAW_HI = 12'h010;

  localparam int CTRL_RAW   = 8;
  localparam int CTRL_BLINK = 9;
  localparam int CTRL_LZS   = 10;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Only the CTRL bits that carry meaning are stored.
  typedef struct packed {
    logic [31:0] data;
    logic [10:0] ctrl;
    logic [7:0]  dp;
    logic [63:0] raw;
  } seg_regs_t;

  localparam seg_regs_t REGS_RESET = '{
    data: 32'h0000_0000,
    ctrl: 11'h0FF,
    dp:   8'h00,
    raw:  {64{1'b1}}
  };

  // Active-low {dp,g,f,e,d,c,b,a} glyphs, entry 0 in the low byte.
  localparam logic [127:0] HEX_SEG_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  function automatic logic [7:0] hex_to_seg(input logic [3:0] value);
    return HEX_SEG_TABLE[{value, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex digit to active-low segment pattern, with optional decimal point.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] value,
  input  logic       dp,
  output logic [7:0] pattern
);

  logic [7:0] glyph_s;

  assign glyph_s = hex_to_seg(value);
  assign pattern = {glyph_s[7] & ~dp, glyph_s[6:0]};

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with IO-mapped registers, per-frame
// shadowing, blink and leading-zero suppression.
module seg_scan_ctrl #(
  parameter int          NUM_DIGITS   = 8,
  parameter int          SCAN_DIV     = 50000,
  parameter int          BLINK_FRAMES = 64,
  parameter logic [11:0] BASE_ADDR    = 12'h000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  IOen,
  input  logic [11:0]           IOaddr,
  input  logic [31:0]           IOwdata,
  output logic [NUM_DIGITS-1:0] led_en,
  output logic [7:0]            seg
);
  import seg_pkg::*;

  localparam int SW = $clog2(SCAN_DIV);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [11:0] ADDR_DATA   = BASE_ADDR + OFF_DATA;
  localparam logic [11:0] ADDR_CTRL   = BASE_ADDR + OFF_CTRL;
  localparam logic [11:0] ADDR_DP     = BASE_ADDR + OFF_DP;
  localparam logic [11:0] ADDR_RAW_LO = BASE_ADDR + OFF_RAW_LO;
  localparam logic [11:0] ADDR_RAW_HI = BASE_ADDR + OFF_RAW_HI;

  seg_regs_t       live_r;
  seg_regs_t       shadow_r;
  logic [SW-1:0]   slot_r;
  logic [2:0]      digit_r;
  logic [BW-1:0]   blink_cnt_r;
  logic            blink_on_r;

  logic            slot_wrap_s;
  logic            frame_end_s;
  logic [7:0]      mask_s;
  logic [3:0]      nibble_s;
  logic            dp_bit_s;
  logic [7:0]      hex_seg_s;
  logic [7:0]      pattern_s;
  logic [7:0]      suppress_s;
  logic            run_zero_s;
  logic            blank_s;
  logic [NUM_DIGITS-1:0] led_next_s;

  assign slot_wrap_s = (slot_r == SW'(SCAN_DIV - 1));
  assign frame_end_s = slot_wrap_s && (digit_r == 3'(NUM_DIGITS - 1));

  // Bus writes into the live register set; unmatched addresses are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_r <= REGS_RESET;
    end else if (IOen) begin
      case (IOaddr)
        ADDR_DATA:   live_r.data       <= IOwdata;
        ADDR_CTRL:   live_r.ctrl       <= IOwdata[10:0];
        ADDR_DP:     live_r.dp         <= IOwdata[7:0];
        ADDR_RAW_LO: live_r.raw[31:0]  <= IOwdata;
        ADDR_RAW_HI: live_r.raw[63:32] <= IOwdata;
        default:     live_r            <= live_r;
      endcase
    end
  end

  // Frame-boundary snapshot; a same-edge write lands in live only, so the frame never tears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_r <= REGS_RESET;
    end else if (frame_end_s) begin
      shadow_r <= live_r;
    end
  end

  // Slot/digit scan counters and the frame-counting blink phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_r      <= '0;
      digit_r     <= 3'd0;
      blink_cnt_r <= '0;
      blink_on_r  <= 1'b1;
    end else begin
      if (slot_wrap_s) begin
        slot_r  <= '0;
        digit_r <= frame_end_s ? 3'd0 : digit_r + 3'd1;
      end else begin
        slot_r  <= slot_r + SW'(1);
      end
      if (frame_end_s) begin
        if (blink_cnt_r == BW'(BLINK_FRAMES - 1)) begin
          blink_cnt_r <= '0;
          blink_on_r  <= ~blink_on_r;
        end else begin
          blink_cnt_r <= blink_cnt_r + BW'(1);
        end
      end
    end
  end

  assign mask_s   = shadow_r.ctrl[7:0];
  assign nibble_s = shadow_r.data[{digit_r, 2'b00} +: 4];
  assign dp_bit_s = shadow_r.dp[digit_r];

  seg_hex_decode u_hex_decode (
    .value   (nibble_s),
    .dp      (dp_bit_s),
    .pattern (hex_seg_s)
  );

  // Leading-zero run from the top digit down; disabled digits neither start nor end it.
  always_comb begin
    run_zero_s = 1'b1;
    suppress_s = 8'h00;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run_zero_s    = run_zero_s & ~(mask_s[i] & (|shadow_r.data[4*i +: 4]));
      suppress_s[i] = run_zero_s & (i != 0) & shadow_r.ctrl[CTRL_LZS] & ~shadow_r.ctrl[CTRL_RAW];
    end
  end

  // Next-cycle pattern and digit enable for the digit currently being scanned.
  always_comb begin
    blank_s = ~mask_s[digit_r]
            | (shadow_r.ctrl[CTRL_BLINK] & ~blink_on_r)
            | suppress_s[digit_r];
    if (shadow_r.ctrl[CTRL_RAW]) begin
      pattern_s = shadow_r.raw[{digit_r, 3'b000} +: 8];
    end else begin
      pattern_s = hex_seg_s;
    end
    led_next_s = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      led_next_s[i] = blank_s | (digit_r != 3'(i));
    end
  end

  // Registered display outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_en <= '1;
      seg    <= SEG_BLANK;
    end else begin
      led_en <= led_next_s;
      seg    <= blank_s ? SEG_BLANK : pattern_s;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: directed vector table, corner sequences
// and randomized register traffic against a cycle-count based reference model.
module tb_seg_scan_ctrl;

  localparam int          ND    = 8;
  localparam int          SDIV  = 4;
  localparam int          BFR   = 2;
  localparam int          FRAME = ND * SDIV;
  localparam logic [11:0] BASE  = 12'h040;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        io_en = 1'b0;
  logic [11:0] io_addr = 12'h000;
  logic [31:0] io_wdata = 32'h0;
  logic [7:0]  led_en;
  logic [7:0]  seg;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] m_data, m_ctrl, m_dp, m_rlo, m_rhi;
  logic [31:0] s_data, s_ctrl, s_dp, s_rlo, s_rhi;

  logic [7:0] hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  typedef struct {
    logic [31:0] ctrl;
    logic [31:0] data;
    logic [31:0] dp;
    logic [31:0] rlo;
    int          digit;
    logic [7:0]  exp_led;
    logic [7:0]  exp_seg;
  } vec_t;

  vec_t vecs [16];

  seg_scan_ctrl #(
    .NUM_DIGITS   (ND),
    .SCAN_DIV     (SDIV),
    .BLINK_FRAMES (BFR),
    .BASE_ADDR    (BASE)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .IOen    (io_en),
    .IOaddr  (io_addr),
    .IOwdata (io_wdata),
    .led_en  (led_en),
    .seg     (seg)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d led_en/seg got=%h expected=%h", name, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_data = 32'h0; m_ctrl = 32'h0000_00FF; m_dp = 32'h0;
    m_rlo = 32'hFFFF_FFFF; m_rhi = 32'hFFFF_FFFF;
    s_data = m_data; s_ctrl = m_ctrl; s_dp = m_dp; s_rlo = m_rlo; s_rhi = m_rhi;
  endtask

  // Display expected after the edge that closes cycle c (cycles counted from reset release).
  function automatic void model_out(input int c, output logic [7:0] le, output logic [7:0] sg);
    int d;
    logic sup, phase_on, blank;
    logic [63:0] raw;
    d = (c / SDIV) % ND;
    phase_on = (((c / FRAME) / BFR) % 2) == 0;
    sup = s_ctrl[10] && !s_ctrl[8] && (d != 0);
    for (int j = d; j < ND; j++)
      if (s_ctrl[j] && s_data[4*j +: 4] != 4'h0) sup = 1'b0;
    blank = !s_ctrl[d] || (s_ctrl[9] && !phase_on) || sup;
    raw = {s_rhi, s_rlo};
    if (blank) begin
      le = 8'hFF; sg = 8'hFF;
    end else begin
      le = ~(8'h01 << d);
      if (s_ctrl[8]) sg = raw[8*d +: 8];
      else begin
        sg = hex_tab[s_data[4*d +: 4]];
        if (s_dp[d]) sg[7] = 1'b0;
      end
    end
  endfunction

  task automatic step();
    logic en; logic [11:0] a; logic [31:0] w; logic [7:0] el, es;
    en = io_en; a = io_addr; w = io_wdata;
    @(posedge clk); #1;
    model_out(cyc, el, es);
    check("scan", {led_en, seg}, {el, es});
    if (cyc % FRAME == FRAME - 1) begin
      s_data = m_data; s_ctrl = m_ctrl; s_dp = m_dp; s_rlo = m_rlo; s_rhi = m_rhi;
    end
    if (en) begin
      if (a == BASE + 12'h000) m_data = w;
      else if (a == BASE + 12'h004) m_ctrl = w;
      else if (a == BASE + 12'h008) m_dp = w;
      else if (a == BASE + 12'h00C) m_rlo = w;
      else if (a == BASE + 12'h010) m_rhi = w;
    end
    cyc++;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic wr(input logic [11:0] off, input logic [31:0] d);
    io_en = 1'b1; io_addr = BASE + off; io_wdata = d;
    step();
    io_en = 1'b0; io_addr = 12'h000; io_wdata = 32'h0;
  endtask

  // Asynchronous reset dropped mid-cycle; outputs must blank before any clock edge.
  task automatic do_reset();
    #3 rst_n = 1'b0;
    #1 check("async_reset", {led_en, seg}, 16'hFFFF);
    io_en = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("reset_hold", {led_en, seg}, 16'hFFFF);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    cyc = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{32'h0FF, 32'h8765_4321, 32'h01, 32'hFFFF_FFFF, 0, 8'hFE, 8'h79};
    vecs[1]  = '{32'h0FF, 32'h8765_4321, 32'h01, 32'hFFFF_FFFF, 7, 8'h7F, 8'h80};
    vecs[2]  = '{32'h0FF, 32'h8765_4321, 32'h01, 32'hFFFF_FFFF, 3, 8'hF7, 8'h99};
    vecs[3]  = '{32'h4FF, 32'h0000_0050, 32'h00, 32'hFFFF_FFFF, 7, 8'hFF, 8'hFF};
    vecs[4]  = '{32'h4FF, 32'h0000_0050, 32'h00, 32'hFFFF_FFFF, 2, 8'hFF, 8'hFF};
    vecs[5]  = '{32'h4FF, 32'h0000_0050, 32'h00, 32'hFFFF_FFFF, 1, 8'hFD, 8'h92};
    vecs[6]  = '{32'h4FF, 32'h0000_0050, 32'h00, 32'hFFFF_FFFF, 0, 8'hFE, 8'hC0};
    vecs[7]  = '{32'h1FF, 32'h0000_0000, 32'hFF, 32'hF0E0_D0C0, 0, 8'hFE, 8'hC0};
    vecs[8]  = '{32'h1FF, 32'h0000_0000, 32'hFF, 32'hF0E0_D0C0, 3, 8'hF7, 8'hF0};
    vecs[9]  = '{32'h1FF, 32'h0000_0000, 32'hFF, 32'hF0E0_D0C0, 4, 8'hEF, 8'hFF};
    vecs[10] = '{32'h47F, 32'h9000_0300, 32'h00, 32'hFFFF_FFFF, 6, 8'hFF, 8'hFF};
    vecs[11] = '{32'h47F, 32'h9000_0300, 32'h00, 32'hFFFF_FFFF, 2, 8'hFB, 8'hB0};
    vecs[12] = '{32'h47F, 32'h9000_0300, 32'h00, 32'hFFFF_FFFF, 1, 8'hFD, 8'hC0};
    vecs[13] = '{32'h00F, 32'h1234_5678, 32'h00, 32'hFFFF_FFFF, 5, 8'hFF, 8'hFF};
    vecs[14] = '{32'h0FF, 32'h0000_00AB, 32'h02, 32'hFFFF_FFFF, 1, 8'hFD, 8'h08};
    vecs[15] = '{32'h4FF, 32'h0000_0000, 32'h00, 32'hFFFF_FFFF, 0, 8'hFE, 8'hC0};

    // Directed table: writes land mid-frame 0 and become visible in frame 1.
    for (int k = 0; k < 16; k++) begin
      do_reset();
      wr(12'h004, vecs[k].ctrl);
      wr(12'h000, vecs[k].data);
      wr(12'h008, vecs[k].dp);
      wr(12'h00C, vecs[k].rlo);
      run_to(FRAME + SDIV * vecs[k].digit + 1);
      check($sformatf("vec%0d", k), {led_en, seg}, {vecs[k].exp_led, vecs[k].exp_seg});
    end

    // Blink phases, then a DATA write in the boundary cycle of frame 3.
    do_reset();
    wr(12'h004, 32'h0000_02FF);
    run_to(FRAME + 1);      check("blink_lit",  {led_en, seg}, 16'hFEC0);
    run_to(2 * FRAME + 1);  check("blink_off",  {led_en, seg}, 16'hFFFF);
    run_to(3 * FRAME + 1);  check("blink_off2", {led_en, seg}, 16'hFFFF);
    run_to(4 * FRAME - 1);
    wr(12'h000, 32'h0000_0007);
    run_to(4 * FRAME + 1);  check("bnd_old",    {led_en, seg}, 16'hFEC0);
    run_to(5 * FRAME + 1);  check("bnd_new",    {led_en, seg}, 16'hFEF8);
    run_to(7 * FRAME);

    // Reset mid-slot restores registers and restarts at digit 0.
    do_reset();
    wr(12'h000, 32'hFFFF_FFFF);
    wr(12'h004, 32'h0000_01FF);
    run_to(50);
    do_reset();
    step();
    check("rst_restore", {led_en, seg}, 16'hFEC0);
    run_to(2 * FRAME);

    // Randomized register traffic, including non-matching addresses and idle strobes.
    for (int r = 0; r < 8; r++) begin
      int offs [8] = '{32'h000, 32'h004, 32'h008, 32'h00C, 32'h010, 32'h014, 32'h002, 32'h800};
      do_reset();
      for (int n = 0; n < 300; n++) begin
        io_addr  = BASE + 12'(offs[$urandom_range(0, 7)]);
        io_wdata = $urandom;
        io_en    = ($urandom_range(0, 5) == 0);
        step();
      end
      io_en = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter NUM_DIGITS, default 8, number of scanned digits, legal range 1..8.
REQ-002 Parameter SCAN_DIV, default 50000, clk cycles per digit slot, minimum 2.
REQ-003 Parameter BLINK_FRAMES, default 64, full frames per blink phase, minimum 1.
REQ-004 Parameter BASE_ADDR, default 12'h000, IO base address of the register block.
REQ-005 clk  input  1  sole clock; all state on rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 IOen  input  1  IO write strobe from bus, one cycle per write.
REQ-008 IOaddr  input  12  IO byte address.
REQ-009 IOwdata  input  32  IO write data.
REQ-010 led_en  output  NUM_DIGITS  digit enables, active-low, registered.
REQ-011 seg  output  8  segments {dp,g,f,e,d,c,b,a}, active-low, registered.

Function
REQ-012 Registers at BASE_ADDR+offset, written when IOen=1 and IOaddr matches exactly; other addresses ignored, no readback.
REQ-013 0x000 DATA: nibble i (bits 4i+3:4i) = hex value of digit i.
REQ-014 0x004 CTRL: [7:0] digit enable mask, [8] raw mode (1=raw, 0=hex decode), [9] blink enable, [10] leading-zero suppression (hex mode only).
REQ-015 0x008 DP: bit i=1 lights dp of digit i (hex mode only).
REQ-016 0x00C RAW_LO / 0x010 RAW_HI: byte i of {RAW_HI,RAW_LO} = active-low segment pattern of digit i in raw mode.
REQ-017 Mask/DP/DATA bits for digits >= NUM_DIGITS ignored.
REQ-018 Slot counter counts 0..SCAN_DIV-1 and wraps; on wrap digit index advances 0..NUM_DIGITS-1 and wraps to 0.
REQ-019 Frame boundary = cycle where slot counter and digit index both wrap; at that edge all live registers copy into shadow registers; display uses only shadows (no tearing).
REQ-020 Write coinciding with frame-boundary edge: shadow takes the pre-write value; new value appears at next frame.
REQ-021 led_en/seg reflect current digit index with exactly one cycle latency; exactly one led_en bit low when the digit is displayed, all high otherwise.
REQ-022 Digit blanked (its led_en high, seg=8'hFF) when its mask bit=0, when blink enabled and blink phase=off, or when suppressed.
REQ-023 Hex decode: 0->C0, 1->F9, 2->A4, 3->B0, 4->99, 5->92, 6->82, 7->F8, 8->80, 9->90, A->88, b->83, C->C6, d->A1, E->86, F->8E; dp bit 7 cleared if DP bit set.
REQ-024 Leading-zero suppression: digits from highest enabled index downward whose nibble is 0 are blanked until first non-zero nibble; digit 0 never suppressed.
REQ-025 Blink counter counts frame boundaries; phase toggles every BLINK_FRAMES frames; phase=on after reset; counter runs whether or not blink enabled.
REQ-026 Disabled digits still consume their slot (constant duty cycle).

Reset
REQ-027 On rst_n low, immediately: led_en all 1, seg=8'hFF, counters/index 0, blink phase on.
REQ-028 Reset values live and shadow: DATA=0, CTRL=32'h0000_00FF (all enabled, hex, no blink, no suppression), DP=0, RAW=all 1s.
REQ-029 Reset mid-frame aborts scan; after release scan restarts at digit 0, slot 0.

Structure
REQ-030 Package seg_pkg holds register offsets, CTRL bit positions, hex-to-segment table constants.
REQ-031 One combinational sub-module seg_hex_decode (4-bit value + dp -> 8-bit pattern).

Verification (SCAN_DIV=4, BLINK_FRAMES=2, NUM_DIGITS=8)
REQ-032 Reset only -> digit 0 low on led_en one cycle after release, seg=C0, index advances every 4 cycles, frame = 32 cycles.
REQ-033 Write DATA=32'h8765_4321, DP=8'h01 mid-frame -> unchanged until next frame boundary; then digit 0 seg=79, digit 7 seg=80.
REQ-034 CTRL=32'h0000_04FF, DATA=32'h0000_0050 -> digits 7..2 blank, digit 1 seg=92, digit 0 seg=C0.
REQ-035 CTRL=32'h0000_01FF, RAW_LO=32'hF0E0_D0C0 -> digits 0..3 show C0,D0,E0,F0; DP ignored.
REQ-036 CTRL=32'h0000_02FF -> 2 frames lit, 2 frames all blank, repeating; write in boundary cycle appears one frame later.
REQ-037 rst_n asserted mid-slot asynchronously -> outputs all 1 same cycle, registers restored per REQ-028.
